// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer wrap increment, default flag margins and the
// occupancy-count width rule.
package fifo_pkg;

  localparam int FIFO_AFULL_MARGIN  = 2;
  localparam int FIFO_AEMPTY_MARGIN = 2;

  // Count must represent 0..DEPTH, hence one bit wider than the address.
  function automatic int fifo_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Increment and wrap a pointer of addr_w bits (natural overflow).
  function automatic logic [31:0] fifo_ptr_inc(input logic [31:0] ptr,
                                               input int          addr_w);
    return (ptr + 32'd1) & ((32'd1 << addr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO controller for an external dual-port RAM with 1-clock read
// latency. Optional sticky overflow/underflow ports under FIFO_RAM_CTRL_ERR_EN.
module fifo_ram_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH         = 256,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - FIFO_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = FIFO_AEMPTY_MARGIN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_RAM_CTRL_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CNT_W = fifo_cnt_w(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] LP_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_AFULL  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] LP_AEMPTY = CNT_W'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rd_vld_p1;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  assign w_full   = (r_count == LP_FULL);
  assign w_empty  = (r_count == '0);
  // A rejected request never borrows the other side's acceptance.
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;

  assign ram_we       = w_wr_acc;
  assign ram_waddr    = r_wr_ptr;
  assign ram_raddr    = r_rd_ptr;
  assign rd_valid     = r_rd_vld_p1;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AFULL);
  assign almost_empty = (r_count <= LP_AEMPTY);
  assign count        = r_count;

  // Stage p0 -> p1: pointer/count update; RAM read data valid one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_rd_acc;
      if (w_wr_acc)
        r_wr_ptr <= ADDR_WIDTH'(fifo_ptr_inc(32'(r_wr_ptr), ADDR_WIDTH));
      if (w_rd_acc)
        r_rd_ptr <= ADDR_WIDTH'(fifo_ptr_inc(32'(r_rd_ptr), ADDR_WIDTH));
      if (w_wr_acc && !w_rd_acc)
        r_count <= r_count + 1'b1;
      else if (w_rd_acc && !w_wr_acc)
        r_count <= r_count - 1'b1;
    end
  end

`ifdef FIFO_RAM_CTRL_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full)
        r_overflow <= 1'b1;
      if (rd_en && w_empty)
        r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Randomized and directed bench for fifo_ram_ctrl (DEPTH=4) with a RAM model
// and a queue-based reference FIFO.
module tb_fifo_ram_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
`ifdef FIFO_RAM_CTRL_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] q[$];
  int         wi = 0;
  int         ri = 0;
  bit         exp_vld = 0;
  logic [7:0] exp_data = '0;
  bit         exp_ovf = 0;
  bit         exp_udf = 0;

  always #5 clk = ~clk;

  fifo_ram_ctrl #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef FIFO_RAM_CTRL_ERR_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .count(count)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= wdata;
    rdata <= mem[ram_raddr];
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit w, input bit rd,
                       input logic [7:0] d);
    int  sz;
    bit  wa, ra;
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; wdata = d;
    #1;
    sz = q.size();
    check_val("count", 32'(count), 32'(sz));
    check_val("empty", 32'(empty), 32'(sz == 0));
    check_val("full", 32'(full), 32'(sz == DEPTH));
    check_val("almost_full", 32'(almost_full), 32'(sz >= 3));
    check_val("almost_empty", 32'(almost_empty), 32'(sz <= 1));
    check_val("ram_we", 32'(ram_we), 32'(w && sz < DEPTH));
    check_val("ram_waddr", 32'(ram_waddr), 32'(wi));
    check_val("ram_raddr", 32'(ram_raddr), 32'(ri));
    check_val("rd_valid", 32'(rd_valid), 32'(exp_vld));
    if (exp_vld) check_val("rdata", 32'(rdata), 32'(exp_data));
`ifdef FIFO_RAM_CTRL_ERR_EN
    check_val("overflow", 32'(overflow), 32'(exp_ovf));
    check_val("underflow", 32'(underflow), 32'(exp_udf));
`endif
    wa = w && (sz < DEPTH);
    ra = rd && (sz > 0);
    @(posedge clk);
    if (r) begin
      q.delete(); wi = 0; ri = 0; exp_vld = 0; exp_ovf = 0; exp_udf = 0;
    end else begin
      if (w && sz == DEPTH) exp_ovf = 1;
      if (rd && sz == 0)    exp_udf = 1;
      exp_vld = ra;
      if (ra) begin
        exp_data = q.pop_front();
        ri = (ri + 1) % DEPTH;
      end
      if (wa) begin
        q.push_back(d);
        wi = (wi + 1) % DEPTH;
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);

    // Idle after reset
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    // Fill A..D, then overflow attempt E
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'hA0 + 8'(i));
    cycle(0, 0, 0, 8'h00);
    // Drain four, then underflow attempt
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 0, 8'h00);
    // Move pointers to 3 with count 2, then wrap with simultaneous rd+wr
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h00);
    cycle(0, 1, 0, 8'h20);
    cycle(0, 1, 0, 8'h21);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 8'h30 + 8'(i));
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 1, 8'h00);
    // Simultaneous request while empty: only the write lands
    cycle(0, 1, 1, 8'h5A);
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 0, 8'h00);
    // Reset mid-stream at count 3
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h60 + 8'(i));
    cycle(1, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 50),
            8'($urandom));
    end
    cycle(0, 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
